// File: rtl/frame_stream_sequencer_pkg.sv
// Shared definitions for the frame stream sequencer and its raster counter:
// FSM state encoding, sideband bit offsets above the data field, and a
// counter-width helper.
package fss_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } fss_state_t;

  // Sideband bits sit directly above the data word: SB_x = DWIDTH + SB_x_OFS.
  localparam int SB_EOF_OFS = 0;
  localparam int SB_EOL_OFS = 1;
  localparam int SB_SOF_OFS = 2;
  localparam int SB_BITS    = 3;

  // Width needed to count 0..range_n-1, never less than one bit.
  function automatic int cnt_width(input int range_n);
    return (range_n > 1) ? $clog2(range_n) : 1;
  endfunction

endpackage

// File: rtl/frame_stream_sequencer_if.sv
// FIFO-facing handshake bundle: the first-word-fall-through input FIFO read
// port and the output FIFO write port.
interface frame_stream_sequencer_if #(
  parameter int DWIDTH = 24
);
  logic [DWIDTH-1:0] in_dout;
  logic              in_empty;
  logic              in_rd_en;
  logic [DWIDTH+2:0] out_din;
  logic              out_full;
  logic              out_wr_en;

  modport master (
    input  in_dout, in_empty, out_full,
    output in_rd_en, out_din, out_wr_en
  );

  modport slave (
    output in_dout, in_empty, out_full,
    input  in_rd_en, out_din, out_wr_en
  );
endinterface

// File: rtl/frame_stream_sequencer_raster_counter.sv
// Raster position counter: x walks words within a line, y walks lines within
// a frame. Also decodes first-of-frame, last-of-line and last-of-frame.
module raster_counter
  import fss_pkg::*;
#(
  parameter int WPL        = 720,
  parameter int IMG_HEIGHT = 540,
  localparam int XW        = cnt_width(WPL),
  localparam int YW        = cnt_width(IMG_HEIGHT)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          first,
  output logic          last_x,
  output logic          last
);

  logic last_y;

  assign last_x = (x == XW'(WPL - 1));
  assign last_y = (y == YW'(IMG_HEIGHT - 1));
  assign first  = (x == '0) && (y == '0);
  assign last   = last_x && last_y;

  // Step one word per advance; wrap x at end of line and y at end of frame.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (last_x) begin
        x <= '0;
        y <= last_y ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_stream_sequencer.sv
// Frame sequencer between the memory-side input FIFO and the pixel pipeline.
// Drops a fixed header per frame, then forwards one frame of words tagged
// with sof/eol/eof, and counts completed frames.
//
// state  | meaning
// IDLE   | waiting for start
// HEADER | popping and discarding header words
// STREAM | passing pixel words input FIFO -> output FIFO with sideband
// DONE   | one-cycle done pulse, frame count update, re-arm or stop
module frame_stream_sequencer
  import fss_pkg::*;
#(
  parameter int DWIDTH          = 24,
  parameter int IMG_WIDTH       = 720,
  parameter int IMG_HEIGHT      = 540,
  parameter int PIXELS_PER_WORD = 1,
  parameter int HEADER_WORDS    = 0,
  parameter bit CONTINUOUS      = 1'b0,
  parameter int FCNT_WIDTH      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  frame_stream_sequencer_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic [FCNT_WIDTH-1:0] frame_count
);

  localparam int WPL      = IMG_WIDTH / PIXELS_PER_WORD;
  localparam int XW       = cnt_width(WPL);
  localparam int YW       = cnt_width(IMG_HEIGHT);
  localparam int HW       = cnt_width(HEADER_WORDS);
  localparam int HDR_LAST = (HEADER_WORDS > 0) ? HEADER_WORDS - 1 : 0;
  localparam int SB_EOF   = DWIDTH + SB_EOF_OFS;
  localparam int SB_EOL   = DWIDTH + SB_EOL_OFS;
  localparam int SB_SOF   = DWIDTH + SB_SOF_OFS;

  // Arming skips the header phase entirely when there is no header.
  localparam fss_state_t ARM_STATE = (HEADER_WORDS > 0) ? ST_HEADER : ST_STREAM;

  fss_state_t state_q, state_d;

  logic [HW-1:0]         hdr_cnt_q;
  logic [FCNT_WIDTH-1:0] frame_cnt_q;
  logic [DWIDTH+2:0]     out_din_w;
  logic                  hdr_pop;
  logic                  xfer;
  logic                  rc_clear;
  logic                  sof, eol, eof;
  logic [XW-1:0]         rc_x;
  logic [YW-1:0]         rc_y;
  logic                  rc_first, rc_last_x, rc_last;
  logic                  unused_rc_pos;

  raster_counter #(
    .WPL        (WPL),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_raster (
    .clock   (clock),
    .reset   (reset),
    .clear   (rc_clear),
    .advance (xfer),
    .x       (rc_x),
    .y       (rc_y),
    .first   (rc_first),
    .last_x  (rc_last_x),
    .last    (rc_last)
  );

  // Coordinates themselves are not needed here; only the decoded flags are.
  assign unused_rc_pos = ^{rc_x, rc_y};

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake decode; the FIFOs see these combinationally.
  always_comb begin
    state_d      = state_q;
    bus.in_rd_en = 1'b0;
    bus.out_wr_en = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    hdr_pop      = 1'b0;
    xfer         = 1'b0;
    rc_clear     = 1'b0;
    sof          = 1'b0;
    eol          = 1'b0;
    eof          = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ARM_STATE;
      end
      ST_HEADER: begin
        busy         = 1'b1;
        hdr_pop      = !bus.in_empty;
        bus.in_rd_en = hdr_pop;
        if (hdr_pop && (hdr_cnt_q == HW'(HDR_LAST))) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        busy          = 1'b1;
        xfer          = !bus.in_empty && !bus.out_full;
        bus.in_rd_en  = xfer;
        bus.out_wr_en = xfer;
        sof           = rc_first;
        eol           = rc_last_x;
        eof           = rc_last;
        if (xfer && rc_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        done     = 1'b1;
        rc_clear = 1'b1;
        state_d  = CONTINUOUS ? ARM_STATE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output word: data passes straight through, sideband only while streaming.
  always_comb begin
    out_din_w              = '0;
    out_din_w[DWIDTH-1:0]  = bus.in_dout;
    out_din_w[SB_SOF]      = sof;
    out_din_w[SB_EOL]      = eol;
    out_din_w[SB_EOF]      = eof;
  end

  assign bus.out_din = out_din_w;

  // Header word counter; wraps to zero on the last header pop.
  always_ff @(posedge clock) begin
    if (reset || (state_q == ST_DONE)) begin
      hdr_cnt_q <= '0;
    end else if (hdr_pop) begin
      hdr_cnt_q <= (hdr_cnt_q == HW'(HDR_LAST)) ? '0 : hdr_cnt_q + 1'b1;
    end
  end

  // Completed-frame counter with natural wrap.
  always_ff @(posedge clock) begin
    if (reset)                   frame_cnt_q <= '0;
    else if (state_q == ST_DONE) frame_cnt_q <= frame_cnt_q + 1'b1;
  end

  assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_frame_stream_sequencer.sv
// Directed bench: three sequencer instances (single-shot with header,
// continuous with header, continuous headerless with a 2-bit frame count)
// fed from simple FIFO models, outputs captured per push.
module tb_frame_stream_sequencer;
  import fss_pkg::*;

  localparam int DW     = 8;
  localparam int OW     = DW + SB_BITS;
  localparam int SB_EOF = DW + SB_EOF_OFS;

  localparam logic [OW-1:0] EXP1 [8] = '{
    11'h4A2, 11'h0A3, 11'h0A4, 11'h2A5, 11'h0A6, 11'h0A7, 11'h0A8, 11'h3A9
  };
  localparam logic [1:0] FSEQ [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset   = 1'b1;
  logic start_a = 1'b0, start_c = 1'b0, start_f = 1'b0;
  logic busy_a, done_a, busy_c, done_c, busy_f, done_f;
  logic [15:0] fc_a, fc_c;
  logic [1:0]  fc_f;

  frame_stream_sequencer_if #(.DWIDTH(DW)) bus_a ();
  frame_stream_sequencer_if #(.DWIDTH(DW)) bus_c ();
  frame_stream_sequencer_if #(.DWIDTH(DW)) bus_f ();

  frame_stream_sequencer #(.DWIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(2), .PIXELS_PER_WORD(1),
    .HEADER_WORDS(2), .CONTINUOUS(1'b0), .FCNT_WIDTH(16)) dut_a (
    .clock(clk), .reset(reset), .start(start_a), .bus(bus_a.master),
    .busy(busy_a), .done(done_a), .frame_count(fc_a));

  frame_stream_sequencer #(.DWIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(2), .PIXELS_PER_WORD(1),
    .HEADER_WORDS(2), .CONTINUOUS(1'b1), .FCNT_WIDTH(16)) dut_c (
    .clock(clk), .reset(reset), .start(start_c), .bus(bus_c.master),
    .busy(busy_c), .done(done_c), .frame_count(fc_c));

  frame_stream_sequencer #(.DWIDTH(DW), .IMG_WIDTH(4), .IMG_HEIGHT(2), .PIXELS_PER_WORD(1),
    .HEADER_WORDS(0), .CONTINUOUS(1'b1), .FCNT_WIDTH(2)) dut_f (
    .clock(clk), .reset(reset), .start(start_f), .bus(bus_f.master),
    .busy(busy_f), .done(done_f), .frame_count(fc_f));

  // FIFO models: memory written by the stimulus, read pointer advanced on pop.
  logic [DW-1:0] mem_a [0:127];
  logic [DW-1:0] mem_c [0:127];
  logic [DW-1:0] mem_f [0:127];
  int wr_a = 0, wr_c = 0, wr_f = 0;
  int rd_a = 0, rd_c = 0, rd_f = 0;
  logic hold_empty_a = 1'b0;
  logic full_a = 1'b0;

  assign bus_a.in_dout  = mem_a[rd_a[6:0]];
  assign bus_a.in_empty = hold_empty_a || (rd_a == wr_a);
  assign bus_a.out_full = full_a;
  assign bus_c.in_dout  = mem_c[rd_c[6:0]];
  assign bus_c.in_empty = (rd_c == wr_c);
  assign bus_c.out_full = 1'b0;
  assign bus_f.in_dout  = mem_f[rd_f[6:0]];
  assign bus_f.in_empty = (rd_f == wr_f);
  assign bus_f.out_full = 1'b0;

  logic [OW-1:0] cap_a [0:127];
  logic [OW-1:0] cap_c [0:127];
  logic [OW-1:0] cap_f [0:127];
  int ncap_a = 0, ncap_c = 0, ncap_f = 0;
  int ndone_a = 0;

  always @(posedge clk) begin
    if (bus_a.in_rd_en) rd_a <= rd_a + 1;
    if (bus_a.out_wr_en) begin
      cap_a[ncap_a[6:0]] <= bus_a.out_din;
      ncap_a <= ncap_a + 1;
    end
    if (done_a) ndone_a <= ndone_a + 1;
  end

  always @(posedge clk) begin
    if (bus_c.in_rd_en) rd_c <= rd_c + 1;
    if (bus_c.out_wr_en) begin
      cap_c[ncap_c[6:0]] <= bus_c.out_din;
      ncap_c <= ncap_c + 1;
    end
  end

  always @(posedge clk) begin
    if (bus_f.in_rd_en) rd_f <= rd_f + 1;
    if (bus_f.out_wr_en) begin
      cap_f[ncap_f[6:0]] <= bus_f.out_din;
      ncap_f <= ncap_f + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected tagged word for position idx (0..7) of a 4x2 frame.
  function automatic logic [OW-1:0] exp_word(input int idx, input logic [DW-1:0] d);
    logic sof, eol, eof;
    sof = (idx == 0);
    eol = ((idx % 4) == 3);
    eof = (idx == 7);
    return {sof, eol, eof, d};
  endfunction

  task automatic push(input int ch, input logic [DW-1:0] v);
    case (ch)
      0: begin mem_a[wr_a[6:0]] = v; wr_a++; end
      1: begin mem_c[wr_c[6:0]] = v; wr_c++; end
      default: begin mem_f[wr_f[6:0]] = v; wr_f++; end
    endcase
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_cap_a(input string tag, input int base, input int n);
    for (int i = 0; i < 100; i++) begin
      if (ncap_a - base >= n) return;
      @(negedge clk);
    end
    check(tag, ncap_a - base, n);
  endtask

  // Run channel a to its done pulse; done must follow the eof push directly
  // and last exactly one cycle, leaving the sequencer idle.
  task automatic run_a(input string tag);
    int   seen;
    logic prev_eof;
    seen     = 0;
    prev_eof = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done_a) begin
        check({tag, "_done_after_eof"}, prev_eof, 1);
        seen = 1;
        break;
      end
      prev_eof = bus_a.out_wr_en && bus_a.out_din[SB_EOF];
    end
    check({tag, "_done_seen"}, seen, 1);
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done_a, 0);
    check({tag, "_idle_busy"}, busy_a, 0);
  endtask

  initial begin
    int base, dbase, seen, k;
    logic pd;

    // Reset state
    for (int i = 0; i < 10; i++) push(0, 8'hA0 + 8'(i));
    repeat (3) @(negedge clk);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_fcount", fc_a, 0);
    check("rst_rd_en", bus_a.in_rd_en, 0);
    check("rst_wr_en", bus_a.out_wr_en, 0);
    check("rst_out_din", bus_a.out_din, 11'h0A0);
    check("rst_fcount_f", fc_f, 0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_no_pop", rd_a, 0);

    // Case 1: plain frame, two header words dropped
    base = ncap_a;
    pulse_start_a();
    check("c1_busy_header", busy_a, 1);
    run_a("c1");
    check("c1_pushes", ncap_a - base, 8);
    for (int i = 0; i < 8; i++) check("c1_word", cap_a[base + i], EXP1[i]);
    check("c1_fcount", fc_a, 1);
    check("c1_pops", rd_a, 10);

    // Case 2: output FIFO full for 3 cycles mid-line
    for (int i = 0; i < 10; i++) push(0, 8'hA0 + 8'(i));
    base = ncap_a;
    pulse_start_a();
    wait_cap_a("c2_wait", base, 2);
    full_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("c2_stall_rd_en", bus_a.in_rd_en, 0);
      check("c2_stall_wr_en", bus_a.out_wr_en, 0);
    end
    full_a = 1'b0;
    run_a("c2");
    check("c2_pushes", ncap_a - base, 8);
    for (int i = 0; i < 8; i++) check("c2_word", cap_a[base + i], EXP1[i]);
    check("c2_fcount", fc_a, 2);

    // Case 3: input FIFO empty toggling randomly for 200 cycles
    for (int i = 0; i < 10; i++) push(0, 8'hB0 + 8'(i));
    base  = ncap_a;
    dbase = ndone_a;
    for (int i = 0; i < 200; i++) begin
      start_a      = (i == 0);
      hold_empty_a = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start_a      = 1'b0;
    hold_empty_a = 1'b0;
    @(negedge clk);
    check("c3_pushes", ncap_a - base, 8);
    check("c3_done_count", ndone_a - dbase, 1);
    for (int i = 0; i < 8; i++) check("c3_word", cap_a[base + i], exp_word(i, 8'hB2 + 8'(i)));
    check("c3_fcount", fc_a, 3);

    // Case 4: continuous mode, 20 words -> two frames
    for (int i = 0; i < 20; i++) push(1, 8'h10 + 8'(i));
    base    = ncap_c;
    start_c = 1'b1;
    @(negedge clk);
    start_c = 1'b0;
    seen    = 0;
    for (int i = 0; i < 100 && seen < 2; i++) begin
      check("c4_busy_vs_done", busy_c, !done_c);
      if (done_c) seen++;
      @(negedge clk);
    end
    check("c4_frames", seen, 2);
    check("c4_fcount", fc_c, 2);
    check("c4_rearmed_busy", busy_c, 1);
    check("c4_pushes", ncap_c - base, 16);
    for (int i = 0; i < 8; i++) check("c4_f0_word", cap_c[base + i], exp_word(i, 8'h12 + 8'(i)));
    for (int i = 0; i < 8; i++) check("c4_f1_word", cap_c[base + 8 + i], exp_word(i, 8'h1C + 8'(i)));

    // Case 6: 2-bit frame count wraps; start held high while busy
    for (int i = 0; i < 40; i++) push(2, 8'h40 + 8'(i));
    base    = ncap_f;
    start_f = 1'b1;
    k       = 0;
    pd      = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (pd) begin
        check("c6_fcount_seq", fc_f, FSEQ[k - 1]);
        check("c6_pushes_per_frame", ncap_f - base, 8 * k);
        if (k == 5) break;
      end
      pd = done_f;
      if (done_f) k++;
    end
    start_f = 1'b0;
    check("c6_frames", k, 5);
    for (int i = 0; i < 40; i++) check("c6_word", cap_f[base + i], exp_word(i % 8, 8'h40 + 8'(i)));

    // Case 5: reset after the 5th push abandons the frame
    for (int i = 0; i < 10; i++) push(0, 8'hC0 + 8'(i));
    base  = ncap_a;
    dbase = ndone_a;
    pulse_start_a();
    wait_cap_a("c5_wait", base, 5);
    hold_empty_a = 1'b1;
    reset        = 1'b1;
    @(negedge clk);
    reset        = 1'b0;
    hold_empty_a = 1'b0;
    check("c5_rst_busy", busy_a, 0);
    check("c5_rst_fcount", fc_a, 0);
    check("c5_rst_done", done_a, 0);
    repeat (3) @(negedge clk);
    check("c5_idle_no_pop", rd_a, 37);
    check("c5_no_done", ndone_a - dbase, 0);
    for (int i = 0; i < 7; i++) push(0, 8'hD0 + 8'(i));
    base = ncap_a;
    pulse_start_a();
    run_a("c5");
    check("c5_pushes", ncap_a - base, 8);
    check("c5_first_sof", cap_a[base], 11'h4C9);
    check("c5_last_eof", cap_a[base + 7], 11'h3D6);
    check("c5_fcount", fc_a, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
